// File: rtl/chunked_subtractor32.sv
// Multi-cycle 32-bit subtractor: input1 - input2 via one reused 5-bit add slice
// (A + ~B + 1), seven slices per operation, with borrow/overflow/zero flags.
module chunked_subtractor32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  output logic [31:0] difference,
  output logic        borrowOut,
  output logic        overflow,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_carry;
  logic [2:0]  r_k;

  logic [4:0]  w_shamt;
  logic [31:0] w_a_sh;
  logic [31:0] w_b_sh;
  logic [5:0]  w_sum;
  logic [31:0] w_diff_next;
  logic        w_last;

  // Slice k covers bits 5k+4:5k; for k=6 the shift leaves only bits 31:30,
  // so operand bits 4:2 are zero-padded and sum bit 2 is the bit-31 carry-out.
  always_comb begin
    w_shamt     = {r_k, 2'b00} + {2'b00, r_k};
    w_a_sh      = r_a >> w_shamt;
    w_b_sh      = r_b >> w_shamt;
    w_sum       = {1'b0, w_a_sh[4:0]} + {1'b0, w_b_sh[4:0]} + {5'd0, r_carry};
    w_last      = (r_k == 3'd6);
    w_diff_next = (difference & ~(32'h0000_001F << w_shamt))
                | ({27'd0, w_sum[4:0]} << w_shamt);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_k        <= '0;
      difference <= '0;
      borrowOut  <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= input1;
            r_b        <= ~input2;
            r_carry    <= 1'b1;
            r_k        <= '0;
            difference <= '0;
            borrowOut  <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
          end
        end
        S_RUN: begin
          difference <= w_diff_next;
          r_carry    <= w_sum[5];
          r_k        <= r_k + 3'd1;
          if (w_last) begin
            r_k       <= '0;
            borrowOut <= ~w_sum[2];
            // r_b holds ~input2, so equal top bits mean operand signs differ
            overflow  <= (r_a[31] == r_b[31]) && (w_diff_next[31] != r_a[31]);
            zero      <= (w_diff_next == 32'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_subtractor32.sv
// Randomized self-checking bench for chunked_subtractor32 against an
// arithmetic reference model (plain 32/64-bit subtraction).
module tb_chunked_subtractor32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] input1 = '0;
  logic [31:0] input2 = '0;
  logic [31:0] difference;
  logic        borrowOut;
  logic        overflow;
  logic        zero;
  logic        busy;
  logic        done;

  int unsigned tests_run = 0;
  int unsigned failed    = 0;

  // observations from the last do_op
  int unsigned obs_lat;
  int unsigned obs_busy;
  logic        obs_done;
  logic        obs_early_flag;
  logic        obs_overlap;
  logic [34:0] obs_vec;
  logic [34:0] obs_hold_vec;
  logic        obs_done_after;

  chunked_subtractor32 dut (
    .clk(clk), .reset(reset), .start(start),
    .input1(input1), .input2(input2),
    .difference(difference), .borrowOut(borrowOut), .overflow(overflow),
    .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] ref_vec(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    longint      sd;
    logic        ov;
    d  = a - b;
    sd = longint'($signed(a)) - longint'($signed(b));
    ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {d, (a < b), ov, (d == 32'd0)};
  endfunction

  function automatic logic [34:0] cur_vec();
    return {difference, borrowOut, overflow, zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation from IDLE and records what the DUT did.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    input1 = a;
    input2 = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    input1 = $urandom;
    input2 = $urandom;
    obs_lat = 1;
    obs_busy = 0;
    obs_early_flag = 1'b0;
    obs_overlap = 1'b0;
    while (!done && obs_lat < 20) begin
      if (busy) obs_busy++;
      if (busy && (borrowOut || overflow || zero)) obs_early_flag = 1'b1;
      tick();
      obs_lat++;
    end
    obs_done = done;
    if (busy && done) obs_overlap = 1'b1;
    obs_vec = cur_vec();
    tick();
    obs_done_after = done;
    obs_hold_vec = cur_vec();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({difference, borrowOut, overflow, zero, busy, done} !== 37'd0) begin
      failed++;
      $display("FAIL reset_outputs: got %h expected 0",
               {difference, borrowOut, overflow, zero, busy, done});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_op(32'd10, 32'd3);
    tests_run++;
    if (obs_lat !== 8 || obs_done !== 1'b1) begin
      failed++;
      $display("FAIL basic_latency: got %0d done=%b expected 8 done=1", obs_lat, obs_done);
    end
    tests_run++;
    if (obs_busy !== 7) begin
      failed++;
      $display("FAIL basic_busy_cycles: got %0d expected 7", obs_busy);
    end
    tests_run++;
    if (obs_vec !== {32'h0000_0007, 3'b000}) begin
      failed++;
      $display("FAIL basic_result: got %h expected %h", obs_vec, {32'h0000_0007, 3'b000});
    end
    tests_run++;
    if (obs_done_after !== 1'b0 || obs_hold_vec !== obs_vec || busy !== 1'b0) begin
      failed++;
      $display("FAIL basic_done_pulse_hold: done_after=%b busy=%b hold=%h expected done=0 busy=0 hold=%h",
               obs_done_after, busy, obs_hold_vec, obs_vec);
    end
    tests_run++;
    if (obs_early_flag !== 1'b0 || obs_overlap !== 1'b0) begin
      failed++;
      $display("FAIL basic_flags_during_run: early=%b overlap=%b expected 0 0",
               obs_early_flag, obs_overlap);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[4] = '{32'd3, 32'h8000_0000, 32'h1234_5678, 32'h0000_0000};
    logic [31:0] tb[4] = '{32'd10, 32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [34:0] ex[4] = '{{32'hFFFF_FFF9, 3'b100}, {32'h7FFF_FFFF, 3'b010},
                           {32'h0000_0000, 3'b001}, {32'h0000_0001, 3'b100}};
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i]);
      tests_run++;
      if (obs_done !== 1'b1 || obs_vec !== ex[i]) begin
        failed++;
        $display("FAIL directed_%0d: got %h done=%b expected %h done=1",
                 i, obs_vec, obs_done, ex[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int unsigned pulses = 0;
    input1 = 32'd100;
    input2 = 32'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    input1 = 32'd5;
    input2 = 32'd9;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        pulses++;
        tests_run++;
        if (cur_vec() !== {32'h0000_0063, 3'b000}) begin
          failed++;
          $display("FAIL ignored_start_result: got %h expected %h",
                   cur_vec(), {32'h0000_0063, 3'b000});
        end
      end
      tick();
    end
    tests_run++;
    if (pulses !== 1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL ignored_start_pulses: got %0d busy=%b expected 1 busy=0", pulses, busy);
    end
    do_op(32'd5, 32'd9);
    tests_run++;
    if (obs_done !== 1'b1 || obs_vec !== {32'hFFFF_FFFC, 3'b100}) begin
      failed++;
      $display("FAIL after_ignored_op: got %h done=%b expected %h done=1",
               obs_vec, obs_done, {32'hFFFF_FFFC, 3'b100});
    end
  endtask

  task automatic test_reset_mid_run();
    int unsigned pulses = 0;
    input1 = 32'h0F0F_1234;
    input2 = 32'h0000_0FFF;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL reset_mid_busy_before: got %b expected 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({difference, borrowOut, overflow, zero, busy, done} !== 37'd0) begin
      failed++;
      $display("FAIL reset_mid_outputs: got %h expected 0",
               {difference, borrowOut, overflow, zero, busy, done});
    end
    for (int c = 0; c < 12; c++) begin
      if (done || busy) pulses++;
      tick();
    end
    tests_run++;
    if (pulses !== 0) begin
      failed++;
      $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", pulses);
    end
    do_op(32'd20, 32'd20);
    tests_run++;
    if (obs_lat !== 8 || obs_done !== 1'b1 || obs_vec !== {32'd0, 3'b001}) begin
      failed++;
      $display("FAIL reset_mid_recover: got lat=%0d vec=%h expected lat=8 vec=%h",
               obs_lat, obs_vec, {32'd0, 3'b001});
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 8)
        0: b = a;
        1: a = {a[31], 31'd0};
        2: b = ~a;
        default: ;
      endcase
      do_op(a, b);
      tests_run++;
      if (obs_lat !== 8 || obs_done !== 1'b1 || obs_vec !== ref_vec(a, b)
          || obs_early_flag !== 1'b0 || obs_overlap !== 1'b0) begin
        failed++;
        $display("FAIL random_%0d: a=%h b=%h got lat=%0d vec=%h early=%b expected lat=8 vec=%h early=0",
                 i, a, b, obs_lat, obs_vec, obs_early_flag, ref_vec(a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_ignored_start();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
